// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - serial TDM frame to 4-bit parallel word demultiplexer
//
// Optional feature macro: FRAME_PARITY_EN
//   undefined : 4-slot frame, completion on slot 3, err constant 0
//   defined   : 5-slot frame, slot 4 carries even parity, err = w0^w1^w2^w3^p
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   din        in   serial data bit
//   din_valid  in   din carries a bit this cycle
//   din_ready  out  block accepts din this cycle (= not shadow_full)
//   sync       in   frame start marker, restarts the slot counter
//   w0..w3     out  demultiplexed word bits (slot0 -> w0)
//   out_valid  out  w0..w3 hold a complete word
//   out_ready  in   downstream consumes the presented word
//   err        out  parity error for the presented word
module tdm_demux4 (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_valid,
  output logic din_ready,
  input  logic sync,
  output logic w0,
  output logic w1,
  output logic w2,
  output logic w3,
  output logic out_valid,
  input  logic out_ready,
  output logic err
);

`ifdef FRAME_PARITY_EN
  localparam logic [2:0] LAST_SLOT = 3'd4;
`else
  localparam logic [2:0] LAST_SLOT = 3'd3;
`endif

  logic [2:0] slot_q, slot_d;
  logic [3:0] shadow_q, shadow_d;
  logic       shadow_full_q, shadow_full_d;
  logic       sh_err_q, sh_err_d;
  logic [3:0] word_q, word_d;
  logic       out_valid_q, out_valid_d;
  logic       err_q, err_d;

  logic       accept;
  logic [2:0] eff_slot;
  logic       complete;
  logic [3:0] new_word;
  logic       new_err;

  // A held shadow word blocks input; din_ready depends on state only.
  assign din_ready = ~shadow_full_q;
  assign accept    = din_valid & ~shadow_full_q;
  // sync forces the arriving bit (if any) into slot 0.
  assign eff_slot  = sync ? 3'd0 : slot_q;
  assign complete  = accept && (eff_slot == LAST_SLOT);

`ifdef FRAME_PARITY_EN
  // Data bits are all in the shadow already; din is the parity bit.
  assign new_word = shadow_q;
  assign new_err  = ^{shadow_q, din};
`else
  // Last data bit arrives on din; err never loads anything but 0.
  assign new_word = {din, shadow_q[2:0]};
  assign new_err  = 1'b0;
`endif

  always_comb begin
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    sh_err_d      = sh_err_q;
    word_d        = word_q;
    out_valid_d   = out_valid_q;
    err_d         = err_q;

    if (accept) begin
      slot_d = complete ? 3'd0 : eff_slot + 3'd1;
      // Slot 4 (parity) is not stored; in 4-slot mode the last bit also
      // lands in shadow[3] so a stalled word is complete in the shadow.
      if (eff_slot != 3'd4) begin
        shadow_d[eff_slot[1:0]] = din;
      end
    end else if (sync) begin
      slot_d = 3'd0;
    end

    if (shadow_full_q && out_ready) begin
      // Pending word moves up; out_valid stays asserted.
      word_d        = shadow_q;
      err_d         = sh_err_q;
      shadow_full_d = 1'b0;
      out_valid_d   = 1'b1;
    end else if (complete) begin
      if (!out_valid_q || out_ready) begin
        word_d      = new_word;
        err_d       = new_err;
        out_valid_d = 1'b1;
      end else begin
        shadow_full_d = 1'b1;
        sh_err_d      = new_err;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q        <= 3'd0;
      shadow_q      <= 4'd0;
      shadow_full_q <= 1'b0;
      sh_err_q      <= 1'b0;
      word_q        <= 4'd0;
      out_valid_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      sh_err_q      <= sh_err_d;
      word_q        <= word_d;
      out_valid_q   <= out_valid_d;
      err_q         <= err_d;
    end
  end

  assign w0        = word_q[0];
  assign w1        = word_q[1];
  assign w2        = word_q[2];
  assign w3        = word_q[3];
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - self-checking bench for tdm_demux4
module tb_tdm_demux4;

`ifdef FRAME_PARITY_EN
  localparam int NSLOT = 5;
`else
  localparam int NSLOT = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic din_ready;
  logic sync = 1'b0;
  logic w0, w1, w2, w3;
  logic out_valid;
  logic out_ready = 1'b0;
  logic err;

  int checks = 0;
  int failures = 0;

  // Model: bits of the frame being collected, and completed words
  // (bit 4 = err, bits 3:0 = word) waiting to be or being presented.
  logic       frame[$];
  logic [4:0] words[$];
  logic [4:0] last_shown = 5'd0;

  always #5 clk = ~clk;

  tdm_demux4 dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sync(sync),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] wout();
    return {w3, w2, w1, w0};
  endfunction

  task automatic model_reset();
    frame.delete();
    words.delete();
    last_shown = 5'd0;
  endtask

  task automatic compare_model();
    logic [4:0] shown;
    shown = (words.size() > 0) ? words[0] : last_shown;
    chk("din_ready", {7'd0, din_ready}, {7'd0, words.size() < 2});
    chk("out_valid", {7'd0, out_valid}, {7'd0, words.size() > 0});
    chk("word", {4'd0, wout()}, {4'd0, shown[3:0]});
    chk("err", {7'd0, err}, {7'd0, shown[4]});
  endtask

  // Drive one cycle of inputs, advance the model over the edge, compare after it.
  task automatic step(input logic v, input logic b, input logic s, input logic r);
    logic acc;
    logic [4:0] nw;
    din_valid = v; din = b; sync = s; out_ready = r;
    acc = v && (words.size() < 2);
    if (words.size() > 0 && r) last_shown = words.pop_front();
    if (acc) begin
      if (s) frame.delete();
      frame.push_back(b);
      if (frame.size() == NSLOT) begin
        nw = 5'd0;
        for (int i = 0; i < 4; i++) nw[i] = frame[i];
        for (int i = 0; i < NSLOT; i++) nw[4] = nw[4] ^ frame[i];
        if (NSLOT == 4) nw[4] = 1'b0;
        words.push_back(nw);
        frame.delete();
      end
    end else if (s) begin
      frame.delete();
    end
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic send_word(input logic [3:0] wd, input logic first_sync,
                           input logic p, input logic r);
    for (int i = 0; i < 4; i++) step(1'b1, wd[i], first_sync && (i == 0), r);
    if (NSLOT == 5) step(1'b1, p, 1'b0, r);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_word", {4'd0, wout()}, 8'h00);
    chk("rst_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_err", {7'd0, err}, 8'h00);
    chk("rst_ready", {7'd0, din_ready}, 8'h01);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    #12;
    chk("por_word", {4'd0, wout()}, 8'h00);
    chk("por_valid", {7'd0, out_valid}, 8'h00);
    chk("por_err", {7'd0, err}, 8'h00);
    chk("por_ready", {7'd0, din_ready}, 8'h01);
    rst = 1'b0;

    // 1,0,1,1 gap-free with out_ready=1 -> 4'b1101 for one cycle
    send_word(4'b1101, 1'b0, 1'b1, 1'b1);
    chk("w1101_valid", {7'd0, out_valid}, 8'h01);
    chk("w1101_word", {4'd0, wout()}, 8'h0d);
    chk("w1101_err", {7'd0, err}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("w1101_drop", {7'd0, out_valid}, 8'h00);
    chk("w1101_hold", {4'd0, wout()}, 8'h0d);

    // Back-pressure: 5 then A with out_ready=0
    send_word(4'h5, 1'b0, 1'b0, 1'b0);
    send_word(4'hA, 1'b0, 1'b0, 1'b0);
    chk("bp_ready", {7'd0, din_ready}, 8'h00);
    chk("bp_first", {4'd0, wout()}, 8'h05);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("bp_stable", {4'd0, wout()}, 8'h05);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_second", {4'd0, wout()}, 8'h0a);
    chk("bp_valid2", {7'd0, out_valid}, 8'h01);
    chk("bp_ready2", {7'd0, din_ready}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_empty", {7'd0, out_valid}, 8'h00);

    // Partial word then sync frame 0,1,1,0 -> single 4'b0110
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    send_word(4'b0110, 1'b1, 1'b0, 1'b1);
    chk("sync_word", {4'd0, wout()}, 8'h06);
    chk("sync_valid", {7'd0, out_valid}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // din_valid toggling with bits 1,1,1,0 -> 4'b0111
    for (int i = 0; i < NSLOT; i++) begin
      logic [4:0] bits;
      bits = 5'b11110;           // slot 4 parity (even over 1,1,1,0) is 1
      if (NSLOT == 4) bits = 5'b00111;
      else bits = 5'b10111;
      step(1'b1, bits[i], 1'b0, 1'b1);
      if (i != NSLOT - 1) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    chk("gap_word", {4'd0, wout()}, 8'h07);
    chk("gap_err", {7'd0, err}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word, then a fresh word
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    do_reset();
    send_word(4'b1001, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_word", {4'd0, wout()}, 8'h09);
    // Reset while a word is presented
    send_word(4'b0011, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_word(4'b0110, 1'b0, 1'b0, 1'b1);
    chk("rst_full_word", {4'd0, wout()}, 8'h06);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef FRAME_PARITY_EN
    send_word(4'b0011, 1'b0, 1'b1, 1'b1);
    chk("par1_word", {4'd0, wout()}, 8'h03);
    chk("par1_err", {7'd0, err}, 8'h01);
    send_word(4'b0011, 1'b0, 1'b0, 1'b1);
    chk("par0_word", {4'd0, wout()}, 8'h03);
    chk("par0_err", {7'd0, err}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have these ports: clk, in, 1, system clock, all state on the rising edge.
REQ-002 The block SHALL have these ports: rst, in, 1, asynchronous active-high reset.
REQ-003 The block SHALL have these ports: din, in, 1, serial data bit, the 4:1 mux output f.
REQ-004 The block SHALL have these ports: din_valid, in, 1, din carries a bit this cycle.
REQ-005 The block SHALL have these ports: din_ready, out, 1, block accepts din this cycle.
REQ-006 The block SHALL have these ports: sync, in, 1, frame start marker.
REQ-007 The block SHALL have these ports: w0, w1, w2, w3, out, 1 each, demultiplexed word bits.
REQ-008 The block SHALL have these ports: out_valid, out, 1, w0..w3 hold a complete word.
REQ-009 The block SHALL have these ports: out_ready, in, 1, downstream consumes the word.
REQ-010 The block SHALL have these ports: err, out, 1, parity error for the presented word.
REQ-011 Clock SHALL be one clock (clk); reset SHALL be asynchronous, active-high (rst).

Function
REQ-012 A bit SHALL be accepted on a rising edge where din_valid=1 and din_ready=1; no other cycle changes the slot.
REQ-013 Slot counter SHALL be 0..3 (0..4 with parity); slot k bit (k<4) goes to shadow bit k, LSB first (slot0->w0, slot3->w3); counter wraps to 0 after last slot.
REQ-014 Word completes on the accepted last-slot bit; if output empty (out_valid=0) or draining (out_ready=1), shadow+last bit SHALL load into w0..w3 on that edge, out_valid=1 next cycle (latency 1 edge).
REQ-015 If the output is full and not draining at completion, the word SHALL be held in the shadow (shadow_full=1) and din_ready SHALL be 0 until it transfers.
REQ-016 Shadow SHALL transfer to the output on the first edge with out_ready=1; out_valid stays 1; shadow_full clears, din_ready returns to 1 next cycle.
REQ-017 out_valid=1, out_ready=1, no pending word: out_valid SHALL go to 0 next cycle; w0..w3 hold last value.
REQ-018 w0..w3, err SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 din_ready SHALL equal NOT shadow_full (combinational from state only, not from din_valid).
REQ-020 sync=1 with an accepted bit: bit SHALL go to slot 0, partial word discarded.
REQ-021 sync=1 without an accepted bit: slot counter SHALL go to 0, partial word discarded.
REQ-022 sync SHALL never discard a completed word (shadow_full or output register).
REQ-023 Words SHALL be delivered in arrival order; none lost or duplicated.

Reset
REQ-024 rst=1 SHALL immediately force: slot=0, shadow and shadow_full=0, w0..w3=0, out_valid=0, err=0, din_ready=1.
REQ-025 Reset mid-word or with a pending word SHALL discard all data; first bit after rst release is slot 0.

Configuration
REQ-026 Macro FRAME_PARITY_EN defined: frame = 5 slots; slot 4 is an even-parity bit; completion on slot 4; err loads with the word as w0^w1^w2^w3^p.
REQ-027 Macro FRAME_PARITY_EN undefined: frame = 4 slots; completion on slot 3; err SHALL be constant 0.

Verification
REQ-028 Reset, out_ready=1, din 1,0,1,1 on consecutive cycles -> one-cycle out_valid, {w3,w2,w1,w0}=4'b1101.
REQ-029 out_ready=0, send 4'h5 then 4'hA -> din_ready=0 after 8th bit; raise out_ready -> 4'h5 then 4'hA, one cycle each.
REQ-030 2 bits, then sync with bits 0,1,1,0 -> single word 4'b0110, no word from partial.
REQ-031 rst pulse mid-word and with out_valid=1 -> outputs 0 before next clk edge; next 4 bits form new word.
REQ-032 din_valid toggling 1,0,1,0... with bits 1,1,1,0 -> word 4'b0111, same as gap-free.
REQ-033 With FRAME_PARITY_EN: bits 1,1,0,0,p=1 -> err=1; p=0 -> err=0; word 4'b0011 both cases.
